// File: rtl/com_pkg.sv
// Shared definitions for the com framer/parser family: bag type codes,
// address/length width and the payload-carrying rule.
package com_pkg;

    localparam int         RAM_AW        = 12;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    typedef logic [RAM_AW-1:0] addr_t;

    localparam logic [3:0] BAG_INIT   = 4'h0;
    localparam logic [3:0] BAG_ACK    = 4'h1;
    localparam logic [3:0] BAG_NAK    = 4'h2;
    localparam logic [3:0] BAG_STL    = 4'h3;
    localparam logic [3:0] BAG_ERROR  = 4'h4;
    localparam logic [3:0] BAG_DIDX   = 4'h5;
    localparam logic [3:0] BAG_DPARAM = 4'h6;
    localparam logic [3:0] BAG_DDIDX  = 4'h7;
    localparam logic [3:0] BAG_DLINK  = 4'h8;
    localparam logic [3:0] BAG_DTYPE  = 4'h9;
    localparam logic [3:0] BAG_DTEMP  = 4'hA;
    localparam logic [3:0] BAG_DATA0  = 4'hD;
    localparam logic [3:0] BAG_DATA1  = 4'hE;

    typedef enum logic [3:0] {
        MAIN_IDLE,
        MAIN_WAIT,
        PREP,
        HEAD_SYNC,
        HEAD_HI,
        HEAD_LO,
        RAM_ADDR,
        RAM_TAKE,
        DATA_SEND,
        CSUM,
        DONE
    } tx_state_e;

    // Control bags (INIT/ACK/NAK/STL/ERROR) and unassigned codes carry no payload.
    function automatic logic has_payload(input logic [3:0] btype);
        case (btype)
            BAG_DIDX, BAG_DPARAM, BAG_DDIDX, BAG_DLINK,
            BAG_DTYPE, BAG_DTEMP, BAG_DATA0, BAG_DATA1: has_payload = 1'b1;
            default:                                    has_payload = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/com_tx_csum.sv
// XOR byte accumulator with synchronous clear and enable; nxt_o exposes the
// value the register will take so a framer can emit it in the same cycle.
module com_tx_csum (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic [7:0] din_i,
    output logic [7:0] acc_o,
    output logic [7:0] nxt_o
);

    logic [7:0] acc_q;
    logic [7:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clr_i)
            acc_d = 8'h00;
        else if (en_i)
            acc_d = acc_q ^ din_i;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            acc_q <= 8'h00;
        else
            acc_q <= acc_d;
    end

    assign acc_o = acc_q;
    assign nxt_o = acc_d;

endmodule

// File: rtl/com_tx.sv
// Byte-serial packet framer: sync, {btype,len} header, RAM payload, XOR
// checksum, presented as a registered valid/ready stream.
module com_tx
    import com_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fs_tx,
    output logic              fd_tx,
    input  logic [3:0]        tx_btype,
    input  logic [RAM_AW-1:0] tx_ram_init,
    input  logic [RAM_AW-1:0] tx_ram_rlen,
    output logic [RAM_AW-1:0] ram_txa,
    input  logic [7:0]        ram_txd,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    tx_state_e   state_q, state_d;
    logic [3:0]  btype_q, btype_d;
    addr_t       addr_q,  addr_d;
    addr_t       len_q,   len_d;
    addr_t       txa_q,   txa_d;
    logic [7:0]  txd_q,   txd_d;
    logic        txv_q,   txv_d;
    logic        fd_q,    fd_d;

    logic        xfer;
    logic        csum_clr;
    logic        csum_en;
    logic [7:0]  csum_acc;
    logic [7:0]  csum_nxt;

    // A transfer needs a byte actually on offer; ready alone is ignored.
    assign xfer = txv_q & tx_ready;

    // Sync byte is excluded from the checksum, and the checksum byte itself
    // is never folded back in.
    assign csum_clr = (state_q == PREP);
    assign csum_en  = xfer && (state_q != HEAD_SYNC) && (state_q != CSUM);

    com_tx_csum u_csum (
        .clk   (clk),
        .rst   (rst),
        .clr_i (csum_clr),
        .en_i  (csum_en),
        .din_i (txd_q),
        .acc_o (csum_acc),
        .nxt_o (csum_nxt)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= MAIN_IDLE;
            btype_q <= 4'h0;
            addr_q  <= '0;
            len_q   <= '0;
            txa_q   <= '0;
            txd_q   <= 8'h00;
            txv_q   <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            btype_q <= btype_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            txa_q   <= txa_d;
            txd_q   <= txd_d;
            txv_q   <= txv_d;
            fd_q    <= fd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        btype_d = btype_q;
        addr_d  = addr_q;
        len_d   = len_q;
        case (state_q)
            MAIN_IDLE: state_d = MAIN_WAIT;
            MAIN_WAIT: if (fs_tx) state_d = PREP;
            PREP: begin
                btype_d = tx_btype;
                addr_d  = tx_ram_init;
                len_d   = has_payload(tx_btype) ? tx_ram_rlen : '0;
                state_d = HEAD_SYNC;
            end
            HEAD_SYNC: if (xfer) state_d = HEAD_HI;
            HEAD_HI:   if (xfer) state_d = HEAD_LO;
            HEAD_LO:   if (xfer) state_d = (len_q != '0) ? RAM_ADDR : CSUM;
            RAM_ADDR:  state_d = RAM_TAKE;
            RAM_TAKE:  state_d = DATA_SEND;
            DATA_SEND: begin
                if (xfer) begin
                    addr_d  = addr_q + addr_t'(1);
                    len_d   = len_q - addr_t'(1);
                    state_d = (len_q == addr_t'(1)) ? CSUM : RAM_ADDR;
                end
            end
            CSUM:      if (xfer) state_d = DONE;
            DONE:      if (!fs_tx) state_d = MAIN_WAIT;
            default:   state_d = MAIN_IDLE;
        endcase
    end

    // Outputs are registered: decode the state being entered so each byte
    // appears together with its state.
    always_comb begin
        txd_d = txd_q;
        txv_d = 1'b0;
        fd_d  = 1'b0;
        txa_d = txa_q;
        case (state_d)
            HEAD_SYNC: begin
                txv_d = 1'b1;
                txd_d = SYNC_BYTE;
            end
            HEAD_HI: begin
                txv_d = 1'b1;
                txd_d = {btype_d, len_d[11:8]};
            end
            HEAD_LO: begin
                txv_d = 1'b1;
                txd_d = len_d[7:0];
            end
            RAM_ADDR: txa_d = addr_d;
            DATA_SEND: begin
                txv_d = 1'b1;
                if (state_q == RAM_TAKE)
                    txd_d = ram_txd;
            end
            CSUM: begin
                txv_d = 1'b1;
                txd_d = csum_nxt;
            end
            DONE:    fd_d = 1'b1;
            default: ;
        endcase
    end

    assign tx_data  = txd_q;
    assign tx_valid = txv_q;
    assign fd_tx    = fd_q;
    assign ram_txa  = txa_q;

endmodule

// File: tb/tb_com_tx.sv
// Directed bench for com_tx: per-scenario tasks with hand-computed byte
// streams, a synchronous RAM model and a line-side monitor.
module tb_com_tx;

    localparam int STALL_LEN = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        fs_tx;
    logic        fd_tx;
    logic [3:0]  tx_btype;
    logic [11:0] tx_ram_init;
    logic [11:0] tx_ram_rlen;
    logic [11:0] ram_txa;
    logic [7:0]  ram_txd;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    com_tx dut (
        .clk         (clk),
        .rst         (rst),
        .fs_tx       (fs_tx),
        .fd_tx       (fd_tx),
        .tx_btype    (tx_btype),
        .tx_ram_init (tx_ram_init),
        .tx_ram_rlen (tx_ram_rlen),
        .ram_txa     (ram_txa),
        .ram_txd     (ram_txd),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready)
    );

    // TX RAM, one-cycle read latency
    logic [7:0] ram [0:4095];
    always @(posedge clk) ram_txd <= ram[ram_txa];

    // Line-side ready with an armable stall window
    int stall_req = 0, stall_served = 0, stall_left = 0, stall_at = 0;
    logic [7:0] rxq [$];
    always @(posedge clk) begin
        #1;
        if (stall_left == 0 && stall_served < stall_req && tx_valid === 1'b1 && rxq.size() == stall_at) begin
            stall_left = STALL_LEN;
            stall_served++;
        end
        if (stall_left > 0) begin
            tx_ready = 1'b0;
            stall_left--;
        end else begin
            tx_ready = 1'b1;
        end
    end

    // Monitor, sampled on the falling edge
    logic [11:0] aq [$];
    logic [11:0] last_a = 12'h000;
    int cyc = 0, last_xfer_cyc = 0, fd_rise_cyc = 0, fd_hi_cnt = 0;
    int stall_seen = 0, stall_bad = 0;
    logic fd_prev = 1'b0;
    logic [7:0] stall_ref = 8'h00;
    always @(negedge clk) begin
        cyc++;
        if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
            rxq.push_back(tx_data);
            last_xfer_cyc = cyc;
        end
        if (ram_txa !== last_a) begin
            aq.push_back(ram_txa);
            last_a = ram_txa;
        end
        if (fd_tx === 1'b1) begin
            fd_hi_cnt++;
            if (fd_prev !== 1'b1) fd_rise_cyc = cyc;
        end
        fd_prev = fd_tx;
        if (tx_ready === 1'b0 && stall_served > 0) begin
            if (tx_valid !== 1'b1) stall_bad++;
            else begin
                stall_seen++;
                if (stall_seen == 1) stall_ref = tx_data;
                else if (tx_data !== stall_ref) stall_bad++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic request(input logic [3:0] bt, input logic [11:0] ia, input logic [11:0] ln);
        tx_btype    = bt;
        tx_ram_init = ia;
        tx_ram_rlen = ln;
        fs_tx       = 1'b1;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick(1);
            if (fd_tx === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_bytes(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (rxq.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        tick(2);
        checks++; if (tx_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got %b need 0", tx_valid); end
        checks++; if (fd_tx !== 1'b0) begin errs++; $display("FAIL reset_fd got %b need 0", fd_tx); end
        checks++; if (tx_data !== 8'h00) begin errs++; $display("FAIL reset_data got %h need 00", tx_data); end
        checks++; if (ram_txa !== 12'h000) begin errs++; $display("FAIL reset_txa got %h need 000", ram_txa); end
        rst = 1'b1;
        tick(2);
    endtask

    task automatic test_ack;
        logic [7:0] exp [4];
        int base, abase;
        bit ok;
        exp   = '{8'hA5, 8'h10, 8'h00, 8'h10};
        base  = rxq.size();
        abase = aq.size();
        request(4'h1, 12'h123, 12'h010);
        wait_done(ok);
        fs_tx = 1'b0;
        tick(1);
        checks++; if (!ok) begin errs++; $display("FAIL ack_done got timeout need fd_tx"); end
        checks++; if (rxq.size() != base + 4) begin errs++; $display("FAIL ack_len got %0d need 4", rxq.size() - base); end
        for (int i = 0; i < 4; i++)
            if (base + i < rxq.size()) begin
                checks++;
                if (rxq[base+i] !== exp[i]) begin errs++; $display("FAIL ack_byte%0d got %h need %h", i, rxq[base+i], exp[i]); end
            end
        checks++; if (fd_rise_cyc != last_xfer_cyc + 1) begin errs++; $display("FAIL ack_fd_lat got %0d need %0d", fd_rise_cyc, last_xfer_cyc + 1); end
        checks++; if (aq.size() != abase || ram_txa !== 12'h000) begin errs++; $display("FAIL ack_txa got %h need 000 untouched", ram_txa); end
        checks++; if (fd_tx !== 1'b0) begin errs++; $display("FAIL ack_fd_release got %b need 0", fd_tx); end
    endtask

    task automatic test_data0;
        // csum = D0^03^11^22^33 = D3
        logic [7:0]  exp [7];
        logic [11:0] aexp [3];
        int base, abase;
        bit ok;
        exp   = '{8'hA5, 8'hD0, 8'h03, 8'h11, 8'h22, 8'h33, 8'hD3};
        aexp  = '{12'h100, 12'h101, 12'h102};
        base  = rxq.size();
        abase = aq.size();
        request(4'hD, 12'h100, 12'h003);
        wait_done(ok);
        tick(3);
        checks++; if (!ok) begin errs++; $display("FAIL d0_done got timeout need fd_tx"); end
        checks++; if (fd_tx !== 1'b1) begin errs++; $display("FAIL d0_fd_hold got %b need 1", fd_tx); end
        fs_tx = 1'b0;
        tick(1);
        checks++; if (fd_tx !== 1'b0 || tx_valid !== 1'b0) begin errs++; $display("FAIL d0_release got fd=%b v=%b need 0/0", fd_tx, tx_valid); end
        checks++; if (rxq.size() != base + 7) begin errs++; $display("FAIL d0_len got %0d need 7", rxq.size() - base); end
        for (int i = 0; i < 7; i++)
            if (base + i < rxq.size()) begin
                checks++;
                if (rxq[base+i] !== exp[i]) begin errs++; $display("FAIL d0_byte%0d got %h need %h", i, rxq[base+i], exp[i]); end
            end
        checks++; if (aq.size() != abase + 3) begin errs++; $display("FAIL d0_addr_cnt got %0d need 3", aq.size() - abase); end
        for (int i = 0; i < 3; i++)
            if (abase + i < aq.size()) begin
                checks++;
                if (aq[abase+i] !== aexp[i]) begin errs++; $display("FAIL d0_addr%0d got %h need %h", i, aq[abase+i], aexp[i]); end
            end
    endtask

    task automatic test_wrap;
        // csum = E0^03^01^02^04 = E4
        logic [7:0]  exp [7];
        logic [11:0] aexp [3];
        int base, abase;
        bit ok;
        exp   = '{8'hA5, 8'hE0, 8'h03, 8'h01, 8'h02, 8'h04, 8'hE4};
        aexp  = '{12'hFFE, 12'hFFF, 12'h000};
        base  = rxq.size();
        abase = aq.size();
        request(4'hE, 12'hFFE, 12'h003);
        wait_done(ok);
        fs_tx = 1'b0;
        tick(1);
        checks++; if (!ok) begin errs++; $display("FAIL wrap_done got timeout need fd_tx"); end
        checks++; if (rxq.size() != base + 7) begin errs++; $display("FAIL wrap_len got %0d need 7", rxq.size() - base); end
        for (int i = 0; i < 7; i++)
            if (base + i < rxq.size()) begin
                checks++;
                if (rxq[base+i] !== exp[i]) begin errs++; $display("FAIL wrap_byte%0d got %h need %h", i, rxq[base+i], exp[i]); end
            end
        checks++; if (aq.size() != abase + 3) begin errs++; $display("FAIL wrap_addr_cnt got %0d need 3", aq.size() - abase); end
        for (int i = 0; i < 3; i++)
            if (abase + i < aq.size()) begin
                checks++;
                if (aq[abase+i] !== aexp[i]) begin errs++; $display("FAIL wrap_addr%0d got %h need %h", i, aq[abase+i], aexp[i]); end
            end
    endtask

    task automatic test_backpressure;
        logic [7:0] exp [7];
        int base, seen0;
        bit ok;
        exp      = '{8'hA5, 8'hD0, 8'h03, 8'h11, 8'h22, 8'h33, 8'hD3};
        base     = rxq.size();
        seen0    = stall_seen;
        stall_at = base + 4;
        stall_req++;
        request(4'hD, 12'h100, 12'h003);
        wait_done(ok);
        fs_tx = 1'b0;
        tick(1);
        checks++; if (!ok) begin errs++; $display("FAIL bp_done got timeout need fd_tx"); end
        checks++; if (stall_seen - seen0 != STALL_LEN) begin errs++; $display("FAIL bp_stall_cycles got %0d need %0d", stall_seen - seen0, STALL_LEN); end
        checks++; if (stall_bad != 0) begin errs++; $display("FAIL bp_stable got %0d unstable cycles need 0", stall_bad); end
        checks++; if (rxq.size() != base + 7) begin errs++; $display("FAIL bp_len got %0d need 7", rxq.size() - base); end
        for (int i = 0; i < 7; i++)
            if (base + i < rxq.size()) begin
                checks++;
                if (rxq[base+i] !== exp[i]) begin errs++; $display("FAIL bp_byte%0d got %h need %h", i, rxq[base+i], exp[i]); end
            end
    endtask

    task automatic test_abort;
        logic [7:0] exp [7];
        int base;
        bit ok;
        exp  = '{8'hA5, 8'hD0, 8'h03, 8'h11, 8'h22, 8'h33, 8'hD3};
        base = rxq.size();
        request(4'hD, 12'h100, 12'h003);
        wait_bytes(base + 2, ok);
        checks++; if (!ok) begin errs++; $display("FAIL abort_reach got timeout need HEAD_LO"); end
        rst   = 1'b0;
        fs_tx = 1'b0;
        tick(1);
        checks++; if (tx_valid !== 1'b0 || fd_tx !== 1'b0) begin errs++; $display("FAIL abort_reset got v=%b fd=%b need 0/0", tx_valid, fd_tx); end
        checks++; if (tx_data !== 8'h00) begin errs++; $display("FAIL abort_data got %h need 00", tx_data); end
        rst = 1'b1;
        tick(2);
        base = rxq.size();
        request(4'hD, 12'h100, 12'h003);
        wait_done(ok);
        fs_tx = 1'b0;
        tick(1);
        checks++; if (!ok) begin errs++; $display("FAIL abort_redo got timeout need fd_tx"); end
        checks++; if (rxq.size() != base + 7) begin errs++; $display("FAIL abort_len got %0d need 7", rxq.size() - base); end
        for (int i = 0; i < 7; i++)
            if (base + i < rxq.size()) begin
                checks++;
                if (rxq[base+i] !== exp[i]) begin errs++; $display("FAIL abort_byte%0d got %h need %h", i, rxq[base+i], exp[i]); end
            end
    endtask

    task automatic test_fs_drop;
        logic [7:0] exp [7];
        int base, fd0;
        bit ok;
        exp  = '{8'hA5, 8'hD0, 8'h03, 8'h11, 8'h22, 8'h33, 8'hD3};
        base = rxq.size();
        fd0  = fd_hi_cnt;
        request(4'hD, 12'h100, 12'h003);
        wait_bytes(base + 4, ok);
        checks++; if (!ok) begin errs++; $display("FAIL drop_reach got timeout need payload"); end
        fs_tx = 1'b0;
        wait_done(ok);
        tick(3);
        checks++; if (!ok) begin errs++; $display("FAIL drop_done got timeout need fd_tx"); end
        checks++; if (fd_hi_cnt - fd0 != 1) begin errs++; $display("FAIL drop_fd_pulse got %0d cycles need 1", fd_hi_cnt - fd0); end
        checks++; if (fd_tx !== 1'b0 || tx_valid !== 1'b0) begin errs++; $display("FAIL drop_idle got fd=%b v=%b need 0/0", fd_tx, tx_valid); end
        checks++; if (rxq.size() != base + 7) begin errs++; $display("FAIL drop_len got %0d need 7", rxq.size() - base); end
        for (int i = 0; i < 7; i++)
            if (base + i < rxq.size()) begin
                checks++;
                if (rxq[base+i] !== exp[i]) begin errs++; $display("FAIL drop_byte%0d got %h need %h", i, rxq[base+i], exp[i]); end
            end
    endtask

    initial begin
        rst         = 1'b0;
        fs_tx       = 1'b0;
        tx_btype    = 4'h0;
        tx_ram_init = 12'h000;
        tx_ram_rlen = 12'h000;
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[12'h100] = 8'h11;
        ram[12'h101] = 8'h22;
        ram[12'h102] = 8'h33;
        ram[12'hFFE] = 8'h01;
        ram[12'hFFF] = 8'h02;
        ram[12'h000] = 8'h04;
        tick(1);
        test_reset;
        test_ack;
        test_data0;
        test_wrap;
        test_backpressure;
        test_abort;
        test_fs_drop;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
